ysyx_25040129_mmem_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares the single main-memory port between the instruction fetch unit (IFU, word reads only) and the load/store unit (LSU, sized reads and writes).
- Sits between the IFU/LSU and the main-memory module.
- Uses the same req/rsp valid-ready handshakes on every side.
- Grants one transaction at a time, round-robin between the two masters, and holds the grant until the response handshake completes.

---
 rtl/ysyx_25040129_mmem_arbiter_pkg.sv | 27 ++
 rtl/ysyx_25040129_rr_pick2.sv | 19 +
 rtl/ysyx_25040129_mmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_ysyx_25040129_mmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_mmem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter and the memory module.
// Holds the read/write size codes carried on the mem_* request fields and the
// arbiter state encoding.
package ysyx_25040129_mmem_arbiter_pkg;

  // Read-size codes (3 bits)
  localparam logic [2:0] NO_MEM_READ     = 3'd0;
  localparam logic [2:0] MEM_READ_BYTE   = 3'd1;
  localparam logic [2:0] MEM_READ_HALF   = 3'd2;
  localparam logic [2:0] MEM_READ_WORD   = 3'd3;
  localparam logic [2:0] MEM_READ_BYTE_U = 3'd4;
  localparam logic [2:0] MEM_READ_HALF_U = 3'd5;

  // Write-size codes (2 bits)
  localparam logic [1:0] NO_MEM_WRITE    = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE  = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF  = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD  = 2'd3;

  // Arbiter states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitIfu = 2'd1,
    StWaitLsu = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_25040129_rr_pick2.sv
// Combinational 2-way round-robin selector.
//   req_i[1:0]    : request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant_i  : master granted last (0 = IFU, 1 = LSU)
//   gnt_o[1:0]    : one-hot grant (all-zero when no request)
module ysyx_25040129_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // On a tie the master that did not win last time gets the grant.
    if (&req_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_25040129_mmem_arbiter.sv
// Two-master, one-slave main-memory arbiter (IFU word reads, LSU sized reads
// and writes). One transaction at a time, round-robin on ties, grant held
// until the response handshake completes.
//   clk/rst          : clock, synchronous active-low reset
//   ifu_req_* / ifu_rsp_* : IFU request (address) and response (read data)
//   lsu_req_* / lsu_rsp_* : LSU request (size codes, address, data), response
//   mem_req_* / mem_rsp_* : shared memory port
//   timeout_err      : sticky flag, a wait state saw no response for
//                      TIMEOUT_CYCLES cycles (0 disables the watchdog)
module ysyx_25040129_mmem_arbiter
  import ysyx_25040129_mmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [2:0]        lsu_read,
  input  logic [1:0]        lsu_write,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [2:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  arb_state_e      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [1:0]      gnt;
  logic            req_hs;

  ysyx_25040129_rr_pick2 u_pick (
    .req_i       ({lsu_req_valid, ifu_req_valid}),
    .last_grant_i(last_grant_q),
    .gnt_o       (gnt)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_req_valid = 1'b0;
    mem_read      = NO_MEM_READ;
    mem_write     = NO_MEM_WRITE;
    mem_addr      = '0;
    mem_wdata     = '0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = '0;
    mem_rsp_ready = 1'b0;
    req_hs        = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt[0]) begin
          mem_req_valid = 1'b1;
          mem_read      = MEM_READ_WORD;
          mem_addr      = ifu_addr;
          ifu_req_ready = mem_req_ready;
        end else if (gnt[1]) begin
          // Forwarded as-is, even with both codes "none".
          mem_req_valid = 1'b1;
          mem_read      = lsu_read;
          mem_write     = lsu_write;
          mem_addr      = lsu_addr;
          mem_wdata     = lsu_wdata;
          lsu_req_ready = mem_req_ready;
        end
        req_hs = mem_req_valid & mem_req_ready;
        if (req_hs) begin
          state_d      = gnt[0] ? StWaitIfu : StWaitLsu;
          last_grant_d = gnt[1];
        end
      end
      StWaitIfu: begin
        ifu_rsp_valid = mem_rsp_valid;
        ifu_rdata     = mem_rdata;
        mem_rsp_ready = ifu_rsp_ready;
        if (mem_rsp_valid && ifu_rsp_ready) state_d = StIdle;
      end
      StWaitLsu: begin
        lsu_rsp_valid = mem_rsp_valid;
        lsu_rdata     = mem_rdata;
        mem_rsp_ready = lsu_rsp_ready;
        if (mem_rsp_valid && lsu_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog: counts response-less wait cycles, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (req_hs) begin
      cnt_d = '0;
    end else if ((TIMEOUT_CYCLES != 0) && (state_q != StIdle) && !mem_rsp_valid &&
                 (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CntMax) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: tb/tb_ysyx_25040129_mmem_arbiter.sv
module tb_ysyx_25040129_mmem_arbiter;
  import ysyx_25040129_mmem_arbiter_pkg::*;

  localparam logic [2:0] RN = NO_MEM_READ;
  localparam logic [2:0] RW = MEM_READ_WORD;
  localparam logic [2:0] RB = MEM_READ_BYTE;
  localparam logic [1:0] WN = NO_MEM_WRITE;
  localparam logic [1:0] WW = MEM_WRITE_WORD;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
  logic [2:0]  lsu_read;
  logic [1:0]  lsu_write;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        timeout_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_25040129_mmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_read(lsu_read),
    .lsu_write(lsu_write), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        ifu_v;  logic [31:0] ifu_a;  logic ifu_rr;
    logic        lsu_v;  logic [2:0]  lsu_rd; logic [1:0] lsu_wr;
    logic [31:0] lsu_a;  logic [31:0] lsu_wd; logic lsu_rr;
    logic        mq_rdy; logic        mr_v;   logic [31:0] mr_d;
  } in_t;

  typedef struct packed {
    logic        mq_v;   logic [2:0]  m_rd;   logic [1:0] m_wr;
    logic [31:0] m_a;    logic [31:0] m_wd;
    logic        ifu_q;  logic        lsu_q;
    logic        ifu_rv; logic [31:0] ifu_rd;
    logic        lsu_rv; logic [31:0] lsu_rd;
    logic        mr_rdy; logic        err;
  } out_t;

  typedef struct { in_t i; out_t e; } vec_t;
  vec_t vq[$];

  function automatic in_t mk_in(input logic iv, input logic [31:0] ia, input logic irr,
                                input logic lv, input logic [2:0] lrd, input logic [1:0] lwr,
                                input logic [31:0] la, input logic [31:0] lwd, input logic lrr,
                                input logic mqr, input logic mrv, input logic [31:0] mrd);
    return {iv, ia, irr, lv, lrd, lwr, la, lwd, lrr, mqr, mrv, mrd};
  endfunction

  function automatic out_t mk_out(input logic mqv, input logic [2:0] mrd, input logic [1:0] mwr,
                                  input logic [31:0] ma, input logic [31:0] mwd,
                                  input logic iq, input logic lq,
                                  input logic irv, input logic [31:0] ird,
                                  input logic lrv, input logic [31:0] lrd,
                                  input logic mrr, input logic er);
    return {mqv, mrd, mwr, ma, mwd, iq, lq, irv, ird, lrv, lrd, mrr, er};
  endfunction

  function automatic out_t sample();
    return {mem_req_valid, mem_read, mem_write, mem_addr, mem_wdata,
            ifu_req_ready, lsu_req_ready, ifu_rsp_valid, ifu_rdata,
            lsu_rsp_valid, lsu_rdata, mem_rsp_ready, timeout_err};
  endfunction

  task automatic drive(input in_t v);
    ifu_req_valid = v.ifu_v;  ifu_addr = v.ifu_a;    ifu_rsp_ready = v.ifu_rr;
    lsu_req_valid = v.lsu_v;  lsu_read = v.lsu_rd;   lsu_write = v.lsu_wr;
    lsu_addr = v.lsu_a;       lsu_wdata = v.lsu_wd;  lsu_rsp_ready = v.lsu_rr;
    mem_req_ready = v.mq_rdy; mem_rsp_valid = v.mr_v; mem_rdata = v.mr_d;
  endtask

  task automatic add(input in_t i, input out_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vq.push_back(v);
  endtask

  task automatic chk_out(input string name, input out_t got, input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  in_t  zi;
  out_t zo;
  in_t  cur;

  initial begin
    zi = '0;
    zo = '0;
    rst = 1'b0;
    drive(zi);

    // Tie from reset: IFU, then LSU, then IFU again.
    do_reset();
    drive(mk_in(1, 32'h8000_0000, 0, 1, RW, WN, 32'h8000_0200, 0, 0, 1, 0, 0));
    #2;
    chk("tie0_ifu_rdy", 32'(ifu_req_ready), 1);
    chk("tie0_lsu_rdy", 32'(lsu_req_ready), 0);
    chk("tie0_addr", mem_addr, 32'h8000_0000);
    step();
    drive(mk_in(1, 32'h8000_0000, 1, 1, RW, WN, 32'h8000_0200, 0, 1, 1, 1, 32'h0000_0413));
    #2;
    chk("tie0_ifu_rsp", 32'(ifu_rsp_valid), 1);
    chk("tie0_ifu_rdata", ifu_rdata, 32'h0000_0413);
    step();
    drive(mk_in(1, 32'h8000_0000, 1, 1, RW, WN, 32'h8000_0200, 0, 1, 1, 0, 0));
    #2;
    chk("tie1_lsu_rdy", 32'(lsu_req_ready), 1);
    chk("tie1_addr", mem_addr, 32'h8000_0200);
    step();
    drive(mk_in(1, 32'h8000_0000, 1, 1, RW, WN, 32'h8000_0200, 0, 1, 1, 1, 32'h55));
    #2;
    chk("tie1_lsu_rsp", 32'(lsu_rsp_valid), 1);
    step();
    drive(mk_in(1, 32'h8000_0000, 1, 1, RW, WN, 32'h8000_0200, 0, 1, 1, 0, 0));
    #2;
    chk("tie2_ifu_rdy", 32'(ifu_req_ready), 1);
    chk("tie2_lsu_rdy", 32'(lsu_req_ready), 0);
    step();
    drive(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 0));
    step();

    // Table-driven sequence, starts from a fresh reset (IDLE, IFU wins the first tie).
    add(zi, zo);
    add(mk_in(1, 32'h8000_0000, 0, 0, RN, WN, 0, 0, 0, 1, 0, 0),
        mk_out(1, RW, WN, 32'h8000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 0, 0),
        mk_out(0, RN, WN, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 32'h0000_0413),
        mk_out(0, RN, WN, 0, 0, 0, 0, 1, 32'h0000_0413, 0, 0, 1, 0));
    add(zi, zo);
    add(mk_in(1, 32'h8000_0004, 0, 1, RW, WN, 32'h8000_0100, 0, 0, 1, 0, 0),
        mk_out(1, RW, WN, 32'h8000_0100, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 32'h8000_0004, 0, 1, RW, WN, 32'h8000_0100, 0, 1, 1, 1, 32'hCAFE_F00D),
        mk_out(0, RN, WN, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 1, 0));
    add(mk_in(1, 32'h8000_0004, 0, 1, RW, WN, 32'h8000_0100, 0, 0, 1, 0, 0),
        mk_out(1, RW, WN, 32'h8000_0004, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 32'h1111_1111),
        mk_out(0, RN, WN, 0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 1, 0));
    add(mk_in(1, 32'h8000_0008, 0, 1, RN, WW, 32'h8000_1000, 32'hDEAD_BEEF, 0, 0, 0, 0),
        mk_out(1, RN, WW, 32'h8000_1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 1, RN, WW, 32'h8000_1000, 32'hDEAD_BEEF, 0, 1, 0, 0),
        mk_out(1, RN, WW, 32'h8000_1000, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 32'h8000_0008, 0, 0, RN, WN, 0, 0, 1, 1, 0, 0),
        mk_out(0, RN, WN, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add(mk_in(1, 32'h8000_0008, 0, 0, RN, WN, 0, 0, 1, 1, 1, 0),
        mk_out(0, RN, WN, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    add(mk_in(1, 32'h8000_0008, 0, 1, RB, WN, 32'h8000_2003, 0, 0, 0, 0, 0),
        mk_out(1, RW, WN, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 1, RB, WN, 32'h8000_2003, 0, 0, 0, 0, 0),
        mk_out(1, RB, WN, 32'h8000_2003, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].i);
      #2;
      chk_out($sformatf("vec%0d", i), sample(), vq[i].e);
      step();
    end

    // Response back-pressure on the LSU (state is IDLE, LSU won last).
    drive(mk_in(0, 0, 0, 1, RW, WN, 32'h8000_0300, 0, 0, 1, 0, 0));
    #2;
    chk("bp_grant", 32'(lsu_req_ready), 1);
    step();
    cur = mk_in(1, 32'h8000_000C, 0, 0, RN, WN, 0, 0, 0, 1, 1, 32'h1234_5678);
    drive(cur);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("bp_hold%0d_rsprdy", k), 32'(mem_rsp_ready), 0);
      chk($sformatf("bp_hold%0d_rspv", k), 32'(lsu_rsp_valid), 1);
      chk($sformatf("bp_hold%0d_reqv", k), {31'd0, mem_req_valid | ifu_req_ready}, 0);
      step();
    end
    cur.lsu_rr = 1'b1;
    drive(cur);
    #2;
    chk("bp_release_rdy", 32'(mem_rsp_ready), 1);
    chk("bp_release_data", lsu_rdata, 32'h1234_5678);
    step();
    cur.lsu_rr = 1'b0;
    cur.mr_v = 1'b0;
    drive(cur);
    #2;
    chk("bp_next_grant", {31'd0, mem_req_valid & ifu_req_ready}, 1);
    chk("bp_next_addr", mem_addr, 32'h8000_000C);
    step();
    drive(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 0));
    step();
    drive(zi);
    step();

    // Watchdog: memory never answers an IFU fetch.
    drive(mk_in(1, 32'h8000_0010, 0, 0, RN, WN, 0, 0, 0, 1, 0, 0));
    step();
    drive(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++) step();
    chk("wd_before", 32'(timeout_err), 0);
    step();
    chk("wd_at_limit", 32'(timeout_err), 1);
    for (int k = 0; k < 3; k++) step();
    chk("wd_sticky", 32'(timeout_err), 1);
    chk("wd_state_kept", 32'(mem_rsp_ready), 1);
    drive(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 0));
    step();
    drive(zi);
    #2;
    chk("wd_after_rsp", 32'(timeout_err), 1);
    do_reset();
    #2;
    chk("wd_cleared", 32'(timeout_err), 0);

    // Reset during WAIT_IFU; after it the tie must go to IFU again.
    drive(mk_in(1, 32'h8000_0020, 0, 0, RN, WN, 0, 0, 0, 1, 0, 0));
    step();
    drive(zi);
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive(mk_in(0, 0, 1, 0, RN, WN, 0, 0, 0, 0, 1, 32'hAAAA_5555));
    #2;
    chk_out("rst_mid_idle", sample(), zo);
    step();
    drive(mk_in(1, 32'h8000_0024, 0, 1, RW, WN, 32'h8000_0400, 0, 0, 0, 0, 0));
    #2;
    chk("rst_tie_addr", mem_addr, 32'h8000_0024);
    chk("rst_tie_valid", 32'(mem_req_valid), 1);
    step();
    drive(zi);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
